pong_game_core: RTL and testbench
=================================

Name: pong_game_core

Overview:
Parametrised game-state engine for the two-player paddle/ball game. It moves both paddles and the ball once per video frame, resolves wall, paddle and goal collisions, keeps scores, and sequences a match through idle, serve, play and game-over. It sits between the button/debounce logic and the pixel renderer, which only reads the position, score and state outputs. It replaces the positions, collision logic and scoring that were previously embedded in the renderer, and adds serve delay, win detection and clamped paddle limits.

Parameters:
CW, 10, coordinate width in bits
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
BORDER, 5, border thickness; the play field is [BORDER, H_ACTIVE-BORDER) x [BORDER, V_ACTIVE-BORDER)
PAD1_X, 40, left edge of paddle 1
PAD2_X, 600, left edge of paddle 2
PAD_WIDTH, 4, paddle width
PAD_HEIGHT, 90, paddle height
PAD_VEL, 2, paddle step per frame
BALL_SIZE, 8, ball square side
BALL_SPEED, 2, ball step per frame on each axis
WIN_SCORE, 9, points needed to win (max 15)
SERVE_FRAMES, 60, number of frames the ball is held before play
SW, 4, score width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
frame_tick  in  1  one-cycle pulse per frame (start of vertical retrace)
start  in  1  start/restart request, level-sampled every cycle
up1  in  1  paddle 1 up
down1  in  1  paddle 1 down
up2  in  1  paddle 2 up
down2  in  1  paddle 2 down
pad1_y  out  CW  paddle 1 top row
pad2_y  out  CW  paddle 2 top row
ball_x  out  CW  ball left column
ball_y  out  CW  ball top row
score1  out  SW  player 1 score
score2  out  SW  player 2 score
state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
winner  out  2  0 = none, 1 = player 1, 2 = player 2
point_pulse  out  1  one-cycle pulse when a point is scored

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate, valid in any state):
  - pad1_y = pad2_y = (V_ACTIVE-PAD_HEIGHT)/2 = 195.
  - ball_x = (H_ACTIVE-BALL_SIZE)/2 = 316; ball_y = (V_ACTIVE-BALL_SIZE)/2 = 236.
  - Internal direction is dx = +BALL_SPEED, dy = +BALL_SPEED.
  - Scores 0, state IDLE, winner 0, point_pulse 0, serve counter 0.
- Latency: all position, score and state effects of a frame_tick in cycle N are visible in cycle N+1. Between ticks, nothing changes except on start.
- IDLE:
  - Paddles and ball are frozen.
  - start=1 moves to SERVE next cycle and loads the serve counter with SERVE_FRAMES.
- SERVE:
  - The ball is held at the centre.
  - Paddles move on each tick.
  - Each tick decrements the counter. The tick that takes the counter from 1 to 0 moves to PLAY, so the ball is held for exactly SERVE_FRAMES ticks.
- PLAY: each tick updates the paddles first, then the ball, using the paddle positions from before the tick.
- Paddle update (SERVE and PLAY):
  - up and down both set, or neither set: no move.
  - up: pad_y = max(pad_y-PAD_VEL, BORDER).
  - down: pad_y = min(pad_y+PAD_VEL, V_ACTIVE-BORDER-PAD_HEIGHT).
  - Moves are clamped at the limits, never refused.
- Ball update (PLAY): candidate position nx = ball_x+dx, ny = ball_y+dy, then:
  - Top: ny < BORDER → ball_y = BORDER, dy = +.
  - Bottom: ny+BALL_SIZE > V_ACTIVE-BORDER → ball_y = V_ACTIVE-BORDER-BALL_SIZE, dy = −.
  - Paddle 1 hit, all of:
    - dx < 0;
    - ball_x ≥ PAD1_X+PAD_WIDTH;
    - nx < PAD1_X+PAD_WIDTH;
    - vertical overlap, [ny, ny+BALL_SIZE) intersects [pad1_y, pad1_y+PAD_HEIGHT).
    - Result: ball_x = PAD1_X+PAD_WIDTH, dx = +.
  - Paddle 2 hit: the mirror case.
    - dx > 0;
    - ball_x+BALL_SIZE ≤ PAD2_X;
    - nx+BALL_SIZE > PAD2_X;
    - vertical overlap with paddle 2.
    - Result: ball_x = PAD2_X-BALL_SIZE, dx = −.
  - Goal:
    - No paddle hit and nx ≤ BORDER → player 2 scores.
    - No paddle hit and nx+BALL_SIZE ≥ H_ACTIVE-BORDER → player 1 scores.
  - A vertical bounce and a paddle hit on the same tick are both applied. A paddle hit takes priority over a goal.
- Point:
  - score += 1 and point_pulse = 1 for one cycle.
  - Ball recentres to 316/236.
  - dx points toward the player who conceded; dy is kept.
  - New score == WIN_SCORE → OVER, winner = scorer. Otherwise → SERVE with the counter reloaded.
  - Scores never exceed WIN_SCORE and never wrap.
- OVER:
  - Everything is frozen.
  - start=1 clears both scores and winner, recentres the ball and paddles, and goes to SERVE.
- start is ignored in SERVE and PLAY.
- Arithmetic is done CW+1 bits wide so that a subtraction below 0 compares correctly and does not wrap.

Test Plan:
1. Reset low with no clock → outputs 195/195/316/236, scores 0, state 0, winner 0. Release reset; pulse start → state 1. After 59 ticks state is 1; after the 60th tick state is 2.
2. Hold up1 in SERVE for 100 ticks → pad1_y steps by 2 and reaches 5 at tick 95, then stays 5. Hold up2 and down2 together → pad2_y stays 195.
3. Let the ball run in PLAY from the top of the field → when ny < 5, ball_y = 5 and the following ticks increase ball_y by 2.
4. Place pad2 so it covers the ball row, then tick until the right edge crosses 600 → ball_x = 592 and the next tick gives ball_x = 590.
5. Park both paddles at 5 so the ball is missed → one point_pulse cycle, score1 or score2 = 1, state 1, ball at 316/236. With WIN_SCORE=3, after the third point by player 1 → state 3, winner 1. Pulse start → scores 0, state 1.
6. Drive reset low mid-PLAY, between clock edges → all outputs take reset values immediately and hold until reset returns high.

Source files
------------

// File: rtl/pong_game_core.sv
// Pong game-state engine: paddles, ball, collisions, scores, match flow.
// Everything advances once per frame_tick; the renderer only reads outputs.
module pong_game_core #(
  parameter int CW           = 10,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BORDER       = 5,
  parameter int PAD1_X       = 40,
  parameter int PAD2_X       = 600,
  parameter int PAD_WIDTH    = 4,
  parameter int PAD_HEIGHT   = 90,
  parameter int PAD_VEL      = 2,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int SW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          start,
  input  logic          up1,
  input  logic          down1,
  input  logic          up2,
  input  logic          down2,
  output logic [CW-1:0] pad1_y,
  output logic [CW-1:0] pad2_y,
  output logic [CW-1:0] ball_x,
  output logic [CW-1:0] ball_y,
  output logic [SW-1:0] score1,
  output logic [SW-1:0] score2,
  output logic [1:0]    state,
  output logic [1:0]    winner,
  output logic          point_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef logic signed [CW:0] sc_t;

  localparam int NW = $clog2(SERVE_FRAMES + 1);

  localparam sc_t S_BORDER = sc_t'(BORDER);
  localparam sc_t S_SPD    = sc_t'(BALL_SPEED);
  localparam sc_t S_BS     = sc_t'(BALL_SIZE);
  localparam sc_t S_PH     = sc_t'(PAD_HEIGHT);
  localparam sc_t S_VEL    = sc_t'(PAD_VEL);
  localparam sc_t S_PBOT   = sc_t'(V_ACTIVE - BORDER - PAD_HEIGHT);
  localparam sc_t S_YBOT   = sc_t'(V_ACTIVE - BORDER - BALL_SIZE);
  localparam sc_t S_P1R    = sc_t'(PAD1_X + PAD_WIDTH);
  localparam sc_t S_P2X    = sc_t'(PAD2_X);
  localparam sc_t S_P2L    = sc_t'(PAD2_X - BALL_SIZE);
  localparam sc_t S_RGT    = sc_t'(H_ACTIVE - BORDER);

  localparam logic [CW-1:0] BALL_CX = CW'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [CW-1:0] BALL_CY = CW'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [CW-1:0] PAD_C   = CW'((V_ACTIVE - PAD_HEIGHT) / 2);
  localparam logic [NW-1:0] SRV_LD  = NW'(SERVE_FRAMES);
  localparam logic [SW-1:0] WIN_S   = SW'(WIN_SCORE);

  state_t st_q, st_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic dxn_q, dxn_d;
  logic dyn_q, dyn_d;
  logic [CW-1:0] p1_d, p2_d, bx_d, by_d;
  logic [SW-1:0] s1_d, s2_d, s1_inc, s2_inc;
  logic [1:0] win_d;
  logic pulse_d;

  sc_t bx_s, by_s, p1_s, p2_s, nx, ny;
  logic ov1, ov2, hit1, hit2, goal1, goal2;

  assign state = st_q;

  function automatic logic [CW-1:0] pad_step(
    input logic [CW-1:0] y,
    input logic          up,
    input logic          dn
  );
    sc_t t;
    t = $signed({1'b0, y});
    if (up && !dn)
      t = (t - S_VEL < S_BORDER) ? S_BORDER : t - S_VEL;
    else if (dn && !up)
      t = (t + S_VEL > S_PBOT) ? S_PBOT : t + S_VEL;
    return t[CW-1:0];
  endfunction

  // Signed, one bit wider, so moves past 0 compare correctly
  assign bx_s = $signed({1'b0, ball_x});
  assign by_s = $signed({1'b0, ball_y});
  assign p1_s = $signed({1'b0, pad1_y});
  assign p2_s = $signed({1'b0, pad2_y});
  assign nx   = dxn_q ? bx_s - S_SPD : bx_s + S_SPD;
  assign ny   = dyn_q ? by_s - S_SPD : by_s + S_SPD;

  assign ov1 = (ny < p1_s + S_PH) && (ny + S_BS > p1_s);
  assign ov2 = (ny < p2_s + S_PH) && (ny + S_BS > p2_s);

  assign hit1 = dxn_q && (bx_s >= S_P1R)
             && (nx < S_P1R) && ov1;
  assign hit2 = !dxn_q && (bx_s + S_BS <= S_P2X)
             && (nx + S_BS > S_P2X) && ov2;

  assign goal2 = !hit1 && !hit2 && (nx <= S_BORDER);
  assign goal1 = !hit1 && !hit2 && !goal2
              && (nx + S_BS >= S_RGT);

  assign s1_inc = score1 + SW'(1);
  assign s2_inc = score2 + SW'(1);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    dxn_d   = dxn_q;
    dyn_d   = dyn_q;
    p1_d    = pad1_y;
    p2_d    = pad2_y;
    bx_d    = ball_x;
    by_d    = ball_y;
    s1_d    = score1;
    s2_d    = score2;
    win_d   = winner;
    pulse_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d  = SERVE;
          cnt_d = SRV_LD;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          p1_d  = pad_step(pad1_y, up1, down1);
          p2_d  = pad_step(pad2_y, up2, down2);
          cnt_d = cnt_q - NW'(1);
          if (cnt_q == NW'(1))
            st_d = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          p1_d = pad_step(pad1_y, up1, down1);
          p2_d = pad_step(pad2_y, up2, down2);
          if (ny < S_BORDER) begin
            by_d  = S_BORDER[CW-1:0];
            dyn_d = 1'b0;
          end else if (ny > S_YBOT) begin
            by_d  = S_YBOT[CW-1:0];
            dyn_d = 1'b1;
          end else begin
            by_d = ny[CW-1:0];
          end
          unique case (1'b1)
            hit1: begin
              bx_d  = S_P1R[CW-1:0];
              dxn_d = 1'b0;
            end
            hit2: begin
              bx_d  = S_P2L[CW-1:0];
              dxn_d = 1'b1;
            end
            goal1, goal2: begin
              pulse_d = 1'b1;
              bx_d    = BALL_CX;
              by_d    = BALL_CY;
              dxn_d   = goal2;
              st_d    = SERVE;
              cnt_d   = SRV_LD;
              if (goal1) begin
                s1_d = s1_inc;
                if (s1_inc == WIN_S) begin
                  st_d  = OVER;
                  win_d = 2'd1;
                end
              end else begin
                s2_d = s2_inc;
                if (s2_inc == WIN_S) begin
                  st_d  = OVER;
                  win_d = 2'd2;
                end
              end
            end
            default: bx_d = nx[CW-1:0];
          endcase
        end
      end
      OVER: begin
        if (start) begin
          s1_d  = '0;
          s2_d  = '0;
          win_d = 2'd0;
          bx_d  = BALL_CX;
          by_d  = BALL_CY;
          p1_d  = PAD_C;
          p2_d  = PAD_C;
          st_d  = SERVE;
          cnt_d = SRV_LD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      dxn_q       <= 1'b0;
      dyn_q       <= 1'b0;
      pad1_y      <= PAD_C;
      pad2_y      <= PAD_C;
      ball_x      <= BALL_CX;
      ball_y      <= BALL_CY;
      score1      <= '0;
      score2      <= '0;
      winner      <= 2'd0;
      point_pulse <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      dxn_q       <= dxn_d;
      dyn_q       <= dyn_d;
      pad1_y      <= p1_d;
      pad2_y      <= p2_d;
      ball_x      <= bx_d;
      ball_y      <= by_d;
      score1      <= s1_d;
      score2      <= s2_d;
      winner      <= win_d;
      point_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_pong_game_core.sv
// Bench for pong_game_core: frame-level game model checked every cycle,
// plus directed scenarios with hand-computed positions and scores.
module tb_pong_game_core;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset;
  logic       frame_tick, start;
  logic       up1, down1, up2, down2;
  logic [9:0] pad1_y, pad2_y, ball_x, ball_y;
  logic [3:0] score1, score2;
  logic [1:0] state, winner;
  logic       point_pulse;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int p1; int p2; int bx; int by;
    int vx; int vy; int s1; int s2;
    int st; int win; int pulse; int cnt;
  } mst_t;

  mst_t m;

  pong_game_core #(
    .WIN_SCORE(3),
    .SERVE_FRAMES(60)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .start(start),
    .up1(up1),
    .down1(down1),
    .up2(up2),
    .down2(down2),
    .pad1_y(pad1_y),
    .pad2_y(pad2_y),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .score1(score1),
    .score2(score2),
    .state(state),
    .winner(winner),
    .point_pulse(point_pulse)
  );

  always #5 if (clk_en) clk = !clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic mst_t mreset();
    mst_t r;
    r = '0;
    r.p1 = 195; r.p2 = 195;
    r.bx = 316; r.by = 236;
    r.vx = 2;   r.vy = 2;
    return r;
  endfunction

  function automatic int padmv(input int y, input bit u, input bit d);
    if (u && !d) return (y - 2 < 5) ? 5 : y - 2;
    if (d && !u) return (y + 2 > 385) ? 385 : y + 2;
    return y;
  endfunction

  // One clock of the game as the rules describe it, in plain integers
  function automatic mst_t mstep(input mst_t c, input bit s, input bit ft,
                                 input bit u1, input bit d1,
                                 input bit u2, input bit d2);
    mst_t n;
    int nx, ny;
    bit ov1, ov2;
    n = c;
    n.pulse = 0;
    if ((c.st == 0 || c.st == 3) && s) begin
      if (c.st == 3) begin
        n.s1 = 0; n.s2 = 0; n.win = 0;
        n.p1 = 195; n.p2 = 195;
        n.bx = 316; n.by = 236;
      end
      n.st = 1;
      n.cnt = 60;
    end else if ((c.st == 1 || c.st == 2) && ft) begin
      n.p1 = padmv(c.p1, u1, d1);
      n.p2 = padmv(c.p2, u2, d2);
      if (c.st == 1) begin
        n.cnt = c.cnt - 1;
        if (n.cnt == 0) n.st = 2;
      end else begin
        nx = c.bx + c.vx;
        ny = c.by + c.vy;
        if (ny < 5) begin
          n.by = 5; n.vy = 2;
        end else if (ny + 8 > 475) begin
          n.by = 467; n.vy = -2;
        end else begin
          n.by = ny;
        end
        ov1 = (ny < c.p1 + 90) && (ny + 8 > c.p1);
        ov2 = (ny < c.p2 + 90) && (ny + 8 > c.p2);
        if (c.vx < 0 && c.bx >= 44 && nx < 44 && ov1) begin
          n.bx = 44; n.vx = 2;
        end else if (c.vx > 0 && c.bx + 8 <= 600 && nx + 8 > 600 && ov2) begin
          n.bx = 592; n.vx = -2;
        end else if (nx <= 5 || nx + 8 >= 635) begin
          n.pulse = 1;
          n.bx = 316; n.by = 236;
          n.st = 1; n.cnt = 60;
          if (nx <= 5) begin
            n.s2 = c.s2 + 1; n.vx = -2;
            if (n.s2 == 3) begin n.st = 3; n.win = 2; end
          end else begin
            n.s1 = c.s1 + 1; n.vx = 2;
            if (n.s1 == 3) begin n.st = 3; n.win = 1; end
          end
        end else begin
          n.bx = nx;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mreset();
    else m <= mstep(m, start, frame_tick, up1, down1, up2, down2);
  end

  always @(negedge clk) begin
    chk("pad1_y", int'(pad1_y), m.p1);
    chk("pad2_y", int'(pad2_y), m.p2);
    chk("ball_x", int'(ball_x), m.bx);
    chk("ball_y", int'(ball_y), m.by);
    chk("score1", int'(score1), m.s1);
    chk("score2", int'(score2), m.s2);
    chk("state", int'(state), m.st);
    chk("winner", int'(winner), m.win);
    chk("point_pulse", int'(point_pulse), m.pulse);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pad1"}, int'(pad1_y), 195);
    chk({tag, "_pad2"}, int'(pad2_y), 195);
    chk({tag, "_bx"}, int'(ball_x), 316);
    chk({tag, "_by"}, int'(ball_y), 236);
    chk({tag, "_s1"}, int'(score1), 0);
    chk({tag, "_s2"}, int'(score2), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_winner"}, int'(winner), 0);
    chk({tag, "_pulse"}, int'(point_pulse), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int pre;
    reset = 1'b1;
    frame_tick = 1'b0; start = 1'b0;
    up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
    #1 reset = 1'b0;
    #4 chk_reset_vals("rst_noclk");
    #3 reset = 1'b1;
    clk_en = 1'b1;
    cyc();
    tick();
    chk("idle_frozen_pad1", int'(pad1_y), 195);
    chk("idle_frozen_state", int'(state), 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_to_serve", int'(state), 1);

    up1 = 1'b1; up2 = 1'b1; down2 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 59) chk("serve_t59", int'(state), 1);
      if (i == 60) chk("serve_t60", int'(state), 2);
      if (i == 94) chk("pad1_t94", int'(pad1_y), 7);
      if (i == 95) chk("pad1_t95", int'(pad1_y), 5);
    end
    chk("pad1_clamped", int'(pad1_y), 5);
    chk("pad2_both", int'(pad2_y), 195);
    chk("ball_x_40play", int'(ball_x), 396);
    chk("ball_y_40play", int'(ball_y), 316);

    up2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      pre = m.vx;
      tick();
      if (pre > 0 && m.vx < 0) found = 1'b1;
    end
    chk("p2_hit_seen", int'(found), 1);
    chk("p2_hit_bx", int'(ball_x), 592);
    chk("p2_hit_by", int'(ball_y), 421);
    chk("p2_pad", int'(pad2_y), 385);
    tick();
    chk("p2_after_bx", int'(ball_x), 590);

    down2 = 1'b0; up2 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      pre = m.vy;
      tick();
      if (pre < 0 && m.vy > 0) found = 1'b1;
    end
    chk("top_seen", int'(found), 1);
    chk("top_by", int'(ball_y), 5);
    tick();
    chk("top_after_by", int'(ball_y), 7);
    tick();
    chk("top_after2_by", int'(ball_y), 9);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      if (m.pulse != 0) begin
        found = 1'b1;
        chk("pt_pulse", int'(point_pulse), 1);
        chk("pt_state", int'(state), 1);
        chk("pt_bx", int'(ball_x), 316);
        chk("pt_by", int'(ball_y), 236);
        chk("pt_s2", int'(score2), 1);
        chk("pt_s1", int'(score1), 0);
      end
      cyc();
    end
    chk("pt_seen", int'(found), 1);
    chk("pt_pulse_gone", int'(point_pulse), 0);

    up1 = 1'b0; up2 = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored_serve", int'(state), 1);
    for (int i = 0; i < 65; i++) tick();
    chk("mid_play", int'(state), 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_async");
    for (int i = 0; i < 3; i++) cyc();
    chk_reset_vals("rst_hold");
    @(negedge clk);
    #2 reset = 1'b1;
    cyc();

    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 1000 && m.st != 3; i++) begin
      up2 = (m.s1 % 2 == 0);
      down2 = !up2;
      tick();
    end
    up2 = 1'b0; down2 = 1'b0;
    chk("win_state", int'(state), 3);
    chk("win_winner", int'(winner), 1);
    chk("win_s1", int'(score1), 3);
    chk("win_s2", int'(score2), 0);
    tick();
    chk("over_frozen", int'(state), 3);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_s1", int'(score1), 0);
    chk("restart_state", int'(state), 1);
    chk("restart_winner", int'(winner), 0);
    chk("restart_pad2", int'(pad2_y), 195);
    chk("restart_bx", int'(ball_x), 316);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
